// File: rtl/stream_argmax_pkg.sv
// Shared types and default sizing for the streaming argmax stage.
// Defaults match the layer generator output: 10 elements of 16-bit signed data.
package stream_argmax_pkg;

    localparam int ARGMAX_M    = 10;
    localparam int ARGMAX_T    = 16;
    localparam int ARGMAX_LOGM = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } argmax_state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Running-max update for one incoming element.
// The first element of a vector loads unconditionally. Later elements replace
// the current best only when they are strictly greater, so ties keep the lowest index.
module argmax_cmp
    import stream_argmax_pkg::*;
#(
    parameter int T    = ARGMAX_T,
    parameter int LOGM = ARGMAX_LOGM
) (
    input  logic [LOGM-1:0]       cnt,
    input  logic signed [T-1:0]   data_in,
    input  logic signed [T-1:0]   best_val,
    input  logic [LOGM-1:0]       best_idx,
    output logic signed [T-1:0]   next_val,
    output logic [LOGM-1:0]       next_idx
);

    // Load on the first element, otherwise take the strictly larger signed value
    always_comb begin
        next_val = best_val;
        next_idx = best_idx;
        if (cnt == '0) begin
            next_val = data_in;
            next_idx = '0;
        end else if (data_in > best_val) begin
            next_val = data_in;
            next_idx = cnt;
        end
    end

endmodule

// File: rtl/stream_argmax_10_16.sv
// Streaming argmax: collects M signed elements, then presents the index of the
// largest one on a valid/ready result port. One result per input vector.
// Optional feature: define STREAM_ARGMAX_MAXVAL_EN to add the max_out port,
// which carries the winning value alongside data_out.
//
// state   | meaning
// --------+--------------------------------------------------------------
// COLLECT | accepting elements, s_ready=1, tracking running max and index
// EMIT    | result held on data_out, m_valid=1, waiting for m_ready
module stream_argmax_10_16
    import stream_argmax_pkg::*;
#(
    parameter int M    = ARGMAX_M,
    parameter int T    = ARGMAX_T,
    parameter int LOGM = ARGMAX_LOGM
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [T-1:0]  data_in,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [LOGM-1:0]      data_out
`ifdef STREAM_ARGMAX_MAXVAL_EN
    ,
    output logic signed [T-1:0]  max_out
`endif
);

    localparam logic [LOGM-1:0] CNT_LAST = LOGM'(M - 1);

    argmax_state_t        state;
    argmax_state_t        state_nxt;
    logic [LOGM-1:0]      cnt;
    logic signed [T-1:0]  best_val;
    logic [LOGM-1:0]      best_idx;
    logic signed [T-1:0]  next_val;
    logic [LOGM-1:0]      next_idx;
    logic                 accept;
    logic                 last_beat;

    assign accept    = s_valid & s_ready;
    assign last_beat = accept && (cnt == CNT_LAST);

    argmax_cmp #(
        .T    (T),
        .LOGM (LOGM)
    ) u_cmp (
        .cnt      (cnt),
        .data_in  (data_in),
        .best_val (best_val),
        .best_idx (best_idx),
        .next_val (next_val),
        .next_idx (next_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave COLLECT on the final element, leave EMIT when the result is taken
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (last_beat) state_nxt = EMIT;
            EMIT:    if (m_ready)   state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Handshake outputs depend on the registered state only
    always_comb begin
        s_ready = (state == COLLECT);
        m_valid = (state == EMIT);
    end

    // Element counter, running max and result capture on the final element
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            best_idx <= '0;
            best_val <= '0;
            data_out <= '0;
        end else if (accept) begin
            best_val <= next_val;
            best_idx <= next_idx;
            if (last_beat) begin
                cnt      <= '0;
                data_out <= next_idx;
            end else begin
                cnt      <= cnt + 1'b1;
            end
        end
    end

`ifdef STREAM_ARGMAX_MAXVAL_EN
    // Winning value, captured in the same cycle as data_out
    always_ff @(posedge clk) begin
        if (reset) begin
            max_out <= '0;
        end else if (last_beat) begin
            max_out <= next_val;
        end
    end
`endif

endmodule
